// File: rtl/hex_scan_ctrl.sv
// Multiplexed hex display scanner: blanking dead time, 16-level PWM and a tear-free
// per-frame snapshot. Define HEX_LZB_EN to enable leading-zero blanking.
module hex_scan_ctrl #(
  parameter int NUM_DIGITS      = 8,
  parameter int CLK_HZ          = 50_000_000,
  parameter int DIGIT_HZ        = 1000,
  parameter int BLANK_CYCLES    = 64,
  parameter bit SEL_ACTIVE_HIGH = 1'b1,
  parameter bit SEG_ACTIVE_LOW  = 1'b1
) (
  input  logic                    clk,
  input  logic                    reset_n,
  input  logic [4*NUM_DIGITS-1:0] data,
  input  logic [NUM_DIGITS-1:0]   dp,
  input  logic [3:0]              brightness,
  input  logic                    disp_en,
  output logic [NUM_DIGITS-1:0]   sel,
  output logic [7:0]              seg,
  output logic                    frame_done
);

  localparam int TICKS = CLK_HZ / DIGIT_HZ;
  localparam int CNT_W = $clog2(TICKS);
  localparam int IDX_W = $clog2(NUM_DIGITS);

  localparam logic [CNT_W-1:0]      LAST_TICK  = CNT_W'(TICKS - 1);
  localparam logic [CNT_W-1:0]      BLANK_LAST = CNT_W'(BLANK_CYCLES - 1);
  localparam logic [IDX_W-1:0]      LAST_IDX   = IDX_W'(NUM_DIGITS - 1);
  localparam logic [NUM_DIGITS-1:0] SEL_OFF    = SEL_ACTIVE_HIGH ? '0 : '1;
  localparam logic [7:0]            SEG_OFF    = SEG_ACTIVE_LOW ? 8'hFF : 8'h00;

  typedef enum logic [1:0] {
    S_IDLE,
    S_BLANK,
    S_ON
  } state_t;

  state_t                  state_q, state_d;
  logic [IDX_W-1:0]        idx_q, idx_d;
  logic [CNT_W-1:0]        slot_q, slot_d;
  logic [3:0]              pwm_q, pwm_d;
  logic [4*NUM_DIGITS-1:0] data_snap_q, data_snap_d;
  logic [NUM_DIGITS-1:0]   dp_snap_q, dp_snap_d;
  logic [3:0]              bright_snap_q, bright_snap_d;
  logic [NUM_DIGITS-1:0]   sel_q, sel_d;
  logic [7:0]              seg_q, seg_d;
  logic                    frame_done_q, frame_done_d;
  logic                    snap_load;
  logic                    lit;
  logic                    blank_digit;
  logic [3:0]              nib;
  logic [7:0]              seg_raw;

  // Active-high a..g pattern for one nibble.
  function automatic logic [6:0] hex7(input logic [3:0] n);
    case (n)
      4'h0: hex7 = 7'h3F;  4'h1: hex7 = 7'h06;  4'h2: hex7 = 7'h5B;  4'h3: hex7 = 7'h4F;
      4'h4: hex7 = 7'h66;  4'h5: hex7 = 7'h6D;  4'h6: hex7 = 7'h7D;  4'h7: hex7 = 7'h07;
      4'h8: hex7 = 7'h7F;  4'h9: hex7 = 7'h6F;  4'hA: hex7 = 7'h77;  4'hB: hex7 = 7'h7C;
      4'hC: hex7 = 7'h39;  4'hD: hex7 = 7'h5E;  4'hE: hex7 = 7'h79;  default: hex7 = 7'h71;
    endcase
  endfunction

  // One slot counter spans the whole digit slot: BLANK for the first BLANK_CYCLES
  // counts, ON for the rest.
  always_comb begin
    // NOTE: every output of a combinational block gets a default first so no latch is inferred.
    state_d   = state_q;
    idx_d     = idx_q;
    slot_d    = slot_q;
    snap_load = 1'b0;
    if (!disp_en) begin
      state_d = S_IDLE;
      idx_d   = '0;
      slot_d  = '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          state_d   = S_BLANK;
          idx_d     = '0;
          slot_d    = '0;
          snap_load = 1'b1;
        end
        S_BLANK: begin
          slot_d = slot_q + 1'b1;
          if (slot_q == BLANK_LAST) state_d = S_ON;
        end
        S_ON: begin
          if (slot_q == LAST_TICK) begin
            state_d = S_BLANK;
            slot_d  = '0;
            if (idx_q == LAST_IDX) begin
              idx_d     = '0;
              snap_load = 1'b1;
            end else begin
              idx_d = idx_q + 1'b1;
            end
          end else begin
            slot_d = slot_q + 1'b1;
          end
        end
        default: state_d = S_IDLE;
      endcase
    end
    pwm_d         = (state_q == S_ON && state_d == S_ON) ? pwm_q + 4'd1 : 4'd0;
    data_snap_d   = snap_load ? data       : data_snap_q;
    dp_snap_d     = snap_load ? dp         : dp_snap_q;
    bright_snap_d = snap_load ? brightness : bright_snap_q;
  end

`ifdef HEX_LZB_EN
  logic [NUM_DIGITS-1:0] lzb_mask;

  // Digit i>0 is blank when it and every higher nibble are zero.
  always_comb begin
    logic zero_run;
    zero_run = 1'b1;
    lzb_mask = '0;
    for (int i = NUM_DIGITS - 1; i > 0; i--) begin
      zero_run    = zero_run & (data_snap_q[i*4 +: 4] == 4'h0);
      lzb_mask[i] = zero_run;
    end
  end

  assign blank_digit = lzb_mask[idx_q];
`else
  assign blank_digit = 1'b0;
`endif

  // Outputs are computed from current state and registered, so pins lag state by one clock.
  always_comb begin
    nib          = data_snap_q[{idx_q, 2'b00} +: 4];
    seg_raw      = {dp_snap_q[idx_q], blank_digit ? 7'h00 : hex7(nib)};
    lit          = disp_en && (state_q == S_ON) && (pwm_q < bright_snap_q);
    sel_d        = lit ? ((NUM_DIGITS'(1) << idx_q) ^ SEL_OFF) : SEL_OFF;
    seg_d        = lit ? (seg_raw ^ SEG_OFF) : SEG_OFF;
    frame_done_d = disp_en && (state_q == S_ON) && (idx_q == LAST_IDX) && (slot_q == LAST_TICK);
  end

  // NOTE: sequential state uses non-blocking assignments so all flops update from pre-edge values.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q       <= S_IDLE;
      idx_q         <= '0;
      slot_q        <= '0;
      pwm_q         <= '0;
      data_snap_q   <= '0;
      dp_snap_q     <= '0;
      bright_snap_q <= '0;
      sel_q         <= SEL_OFF;
      seg_q         <= SEG_OFF;
      frame_done_q  <= 1'b0;
    end else begin
      state_q       <= state_d;
      idx_q         <= idx_d;
      slot_q        <= slot_d;
      pwm_q         <= pwm_d;
      data_snap_q   <= data_snap_d;
      dp_snap_q     <= dp_snap_d;
      bright_snap_q <= bright_snap_d;
      sel_q         <= sel_d;
      seg_q         <= seg_d;
      frame_done_q  <= frame_done_d;
    end
  end

  assign sel        = sel_q;
  assign seg        = seg_q;
  assign frame_done = frame_done_q;

endmodule
